// File: rtl/noc_ni_pkg.sv
// Shared flit layout, RX queue entry format and small helpers for the local
// network interface.
package noc_ni_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int ADDR_W      = 3;
  localparam int SEQ_W       = 4;
  localparam int PAYLOAD_W   = 22;
  localparam int NUM_NODES   = 8;
  localparam int CNT_W       = 8;

  // Field order matches the wire format: dst in the LSBs, payload on top.
  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic [SEQ_W-1:0]     seq;
    logic [ADDR_W-1:0]    src;
    logic [ADDR_W-1:0]    dst;
  } flit_t;

  typedef struct packed {
    logic [ADDR_W-1:0]    src;
    logic [SEQ_W-1:0]     seq;
    logic [PAYLOAD_W-1:0] payload;
  } rx_entry_t;

  localparam int RX_ENTRY_W = $bits(rx_entry_t);

  function automatic flit_t make_flit(input logic [PAYLOAD_W-1:0] payload,
                                      input logic [SEQ_W-1:0]     seq,
                                      input logic [ADDR_W-1:0]    src,
                                      input logic [ADDR_W-1:0]    dst);
    flit_t f;
    f.payload = payload;
    f.seq     = seq;
    f.src     = src;
    f.dst     = dst;
    return f;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/ni_rx_fifo.sv
// First-word-fall-through RX queue. Push into a full queue is accepted when a
// pop happens on the same edge (the popped slot is the one being written).
module ni_rx_fifo
  import noc_ni_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = RX_ENTRY_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign valid   = (count != '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & valid;
  assign do_push = push & (~full | do_pop);
  assign dout    = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/noc_local_ni.sv
// PE <-> router LOCAL port network interface: single-entry TX hold register
// with per-destination sequencing, and a filtering, sequence-checking RX path.
module noc_local_ni
  import noc_ni_pkg::*;
#(
  parameter logic [2:0] NODE_ADDRESS = 3'b0,
  parameter int         RX_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pe_tx_valid,
  output logic        pe_tx_ready,
  input  logic [2:0]  pe_tx_dst,
  input  logic [21:0] pe_tx_payload,
  output logic [31:0] ni_data_out,
  output logic        ni_valid_out,
  input  logic        router_full_in,
  input  logic [31:0] router_data_in,
  input  logic        router_valid_in,
  output logic        pe_rx_valid,
  input  logic        pe_rx_ready,
  output logic [2:0]  pe_rx_src,
  output logic [3:0]  pe_rx_seq,
  output logic [21:0] pe_rx_payload,
  output logic [7:0]  rx_drop_cnt,
  output logic [7:0]  rx_misroute_cnt,
  output logic [7:0]  rx_seq_err_cnt
);

  // ---------------- TX ----------------
  logic                                hold_valid;
  flit_t                               hold_flit;
  logic [NUM_NODES-1:0][SEQ_W-1:0]     tx_seq;
  logic                                tx_hs;

  assign ni_valid_out = hold_valid & ~router_full_in;
  assign pe_tx_ready  = ~hold_valid | ni_valid_out;
  assign ni_data_out  = hold_flit;
  assign tx_hs        = pe_tx_valid & pe_tx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_flit  <= '0;
      tx_seq     <= '0;
    end else if (tx_hs) begin
      // A new message may replace a flit leaving on this same edge.
      hold_valid         <= 1'b1;
      hold_flit          <= make_flit(pe_tx_payload, tx_seq[pe_tx_dst], NODE_ADDRESS, pe_tx_dst);
      tx_seq[pe_tx_dst]  <= tx_seq[pe_tx_dst] + 1'b1;
    end else if (ni_valid_out) begin
      hold_valid <= 1'b0;
    end
  end

  // ---------------- RX ----------------
  logic                                s1_valid;
  flit_t                               s1_flit;
  logic [NUM_NODES-1:0][SEQ_W-1:0]     rx_exp;
  logic                                rx_hit, rx_misroute, rx_drop, rx_push, rx_seq_err;
  logic                                fifo_full, pe_pop;
  rx_entry_t                           push_entry, head;
  logic [RX_ENTRY_W-1:0]               fifo_dout;

  // No backpressure toward the router, so stage 1 samples every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_flit  <= '0;
    end else begin
      s1_valid <= router_valid_in;
      s1_flit  <= router_data_in;
    end
  end

  assign pe_pop      = pe_rx_valid & pe_rx_ready;
  assign rx_hit      = (s1_flit.dst == NODE_ADDRESS);
  assign rx_misroute = s1_valid & ~rx_hit;
  assign rx_drop     = s1_valid & rx_hit & fifo_full & ~pe_pop;
  assign rx_push     = s1_valid & rx_hit & ~(fifo_full & ~pe_pop);
  assign rx_seq_err  = rx_push & (s1_flit.seq != rx_exp[s1_flit.src]);

  assign push_entry.src     = s1_flit.src;
  assign push_entry.seq     = s1_flit.seq;
  assign push_entry.payload = s1_flit.payload;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_exp          <= '0;
      rx_drop_cnt     <= '0;
      rx_misroute_cnt <= '0;
      rx_seq_err_cnt  <= '0;
    end else begin
      // Expected sequence resyncs on every pushed flit, error or not.
      if (rx_push)     rx_exp[s1_flit.src] <= s1_flit.seq + 1'b1;
      if (rx_seq_err)  rx_seq_err_cnt      <= sat_inc(rx_seq_err_cnt);
      if (rx_drop)     rx_drop_cnt         <= sat_inc(rx_drop_cnt);
      if (rx_misroute) rx_misroute_cnt     <= sat_inc(rx_misroute_cnt);
    end
  end

  ni_rx_fifo #(
    .DEPTH (RX_DEPTH),
    .WIDTH (RX_ENTRY_W)
  ) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_push),
    .din   (push_entry),
    .pop   (pe_pop),
    .dout  (fifo_dout),
    .valid (pe_rx_valid),
    .full  (fifo_full)
  );

  assign head          = fifo_dout;
  assign pe_rx_src     = head.src;
  assign pe_rx_seq     = head.seq;
  assign pe_rx_payload = head.payload;

endmodule
